// File: rtl/inst_split_unit_if.sv
// Fetch-to-decode instruction handshake bundle for the store splitter.
// The slave modport is the splitter's view, the master modport is the surrounding pipeline's view.
interface inst_split_unit_if #(
   parameter int WIDTH_INST = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH_INST-1:0] inst_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH_INST-1:0] inst_out;
   logic                  out_is_pre;

   modport slave (
      input  in_valid, inst_in, out_ready,
      output in_ready, out_valid, inst_out, out_is_pre
   );

   modport master (
      output in_valid, inst_in, out_ready,
      input  in_ready, out_valid, inst_out, out_is_pre
   );
endinterface

// File: rtl/inst_split_unit.sv
// Registered instruction splitter: SB/SH stores are issued as a pre-load LW to the same
// address followed by the original store, so the memory stage can do read-modify-write.
module inst_split_unit #(
   parameter int         WIDTH_INST  = 32,
   parameter logic [4:0] SCRATCH_REG = 5'd0,
   parameter bit         SPLIT_SB    = 1'b1,
   parameter bit         SPLIT_SH    = 1'b1,
   parameter int         CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   inst_split_unit_if.slave bus,
   output logic [CNT_W-1:0] split_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      ORIG = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [WIDTH_INST-1:0] inst_q,  inst_d;
   logic [WIDTH_INST-1:0] hold_q,  hold_d;
   logic                  pre_q,   pre_d;
   logic [CNT_W-1:0]      cnt_q,   cnt_d;

   logic                  split_hit;
   logic                  accept;
   logic [WIDTH_INST-1:0] preload;

   assign split_hit = (bus.inst_in[6:0] == 7'b0100011) &&
                      (((bus.inst_in[14:12] == 3'b000) && SPLIT_SB) ||
                       ((bus.inst_in[14:12] == 3'b001) && SPLIT_SH));

   // Same base register and unmodified store offset; the memory stage drops addr[1:0].
   assign preload = WIDTH_INST'({bus.inst_in[31:25], bus.inst_in[11:7], bus.inst_in[19:15],
                                 3'b010, SCRATCH_REG, 7'b0000011});

   assign bus.in_ready   = rst_n && !flush &&
                           ((state_q == IDLE) || ((state_q == ORIG) && bus.out_ready));
   assign accept         = bus.in_valid && bus.in_ready;
   assign bus.out_valid  = (state_q != IDLE);
   assign bus.inst_out   = inst_q;
   assign bus.out_is_pre = pre_q;
   assign split_cnt      = cnt_q;

   always_comb begin
      state_d = state_q;
      inst_d  = inst_q;
      hold_d  = hold_q;
      pre_d   = pre_q;
      cnt_d   = cnt_q;

      if (flush) begin
         state_d = IDLE;
         hold_d  = '0;
         pre_d   = 1'b0;
      end else if (accept) begin
         if (split_hit) begin
            state_d = PRE;
            inst_d  = preload;
            hold_d  = bus.inst_in;
            pre_d   = 1'b1;
         end else begin
            state_d = ORIG;
            inst_d  = bus.inst_in;
            pre_d   = 1'b0;
         end
      end else begin
         case (state_q)
            PRE: begin
               if (bus.out_ready) begin
                  state_d = ORIG;
                  inst_d  = hold_q;
                  pre_d   = 1'b0;
               end
            end
            ORIG: begin
               if (bus.out_ready) begin
                  state_d = IDLE;
                  pre_d   = 1'b0;
               end
            end
            IDLE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      // Saturating statistic; accept is already masked by flush.
      if (accept && split_hit && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         inst_q  <= '0;
         hold_q  <= '0;
         pre_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         hold_q  <= hold_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
